// File: rtl/test_method_responder_if.sv
// test_method_if
//   Req/busy/return method-call handshake between a caller and the
//   self-check responder.
//   Signals:
//     test_idx    caller -> responder  call argument, sampled on accept
//     test_req    caller -> responder  request level; a call starts on its rising edge
//     test_busy   responder -> caller  high while a call is in progress
//     test_return responder -> caller  1 = computed sum matched closed form
//     test_sum    responder -> caller  sum of the last call
//   Modports: master = caller, slave = responder.
interface test_method_if #(
  parameter int WIDTH = 32
);
  logic [31:0]      test_idx;
  logic             test_req;
  logic             test_busy;
  logic             test_return;
  logic [WIDTH-1:0] test_sum;

  modport master (
    output test_idx,
    output test_req,
    input  test_busy,
    input  test_return,
    input  test_sum
  );

  modport slave (
    input  test_idx,
    input  test_req,
    output test_busy,
    output test_return,
    output test_sum
  );
endinterface

// File: rtl/test_method_responder.sv
// test_method_responder
//   Known-good method target: on a rising edge of test_req it iteratively
//   sums 0..test_idx and compares the total against idx*(idx+1)/2.
//   Indices above MAX_N are rejected with return = 0, sum = 0.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high; aborts any call in progress
//     mif    handshake (slave side): test_idx, test_req in;
//            test_busy, test_return, test_sum out (all registered)
module test_method_responder #(
  parameter int WIDTH = 32,
  parameter int MAX_N = 1000
) (
  input  logic          clk,
  input  logic          reset,
  test_method_if.slave  mif
);
  localparam int IDX_W = 32;

  typedef enum logic [1:0] {IDLE, REJ, ACC, CHK} state_t;

  state_t             state_q, state_d;
  logic               req_q;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   i_q, i_d;
  logic [IDX_W-1:0]   n_q, n_d;
  logic               busy_q, busy_d;
  logic               ret_q, ret_d;
  logic [WIDTH-1:0]   sum_q, sum_d;

  logic               accept;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   expected;

  // Only a fresh rising edge of req in IDLE starts a call; a level held
  // across completion never retriggers, and edges while busy are dropped.
  assign accept = (state_q == IDLE) && mif.test_req && !req_q;

  // Closed form in double width so n*(n+1) cannot overflow before the halving;
  // bits [WIDTH:1] are the shift-right-by-one truncated back to WIDTH.
  assign prod     = (2*WIDTH)'(n_q) * ((2*WIDTH)'(n_q) + (2*WIDTH)'(1));
  assign expected = prod[WIDTH:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      acc_q   <= '0;
      i_q     <= '0;
      n_q     <= '0;
      busy_q  <= 1'b0;
      ret_q   <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= mif.test_req;
      acc_q   <= acc_d;
      i_q     <= i_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
      ret_q   <= ret_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    i_d     = i_q;
    n_d     = n_q;
    busy_d  = busy_q;
    ret_d   = ret_q;
    sum_d   = sum_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          busy_d = 1'b1;
          ret_d  = 1'b0;
          if (mif.test_idx > IDX_W'(MAX_N)) begin
            state_d = REJ;
          end else begin
            state_d = ACC;
            n_d     = mif.test_idx;
            i_d     = '0;
            acc_d   = '0;
          end
        end
      end
      REJ: begin
        sum_d   = '0;
        ret_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      ACC: begin
        // The i == n term is still added on the last ACC cycle.
        acc_d = acc_q + WIDTH'(i_q);
        i_d   = i_q + IDX_W'(1);
        if (i_q == n_q) state_d = CHK;
      end
      CHK: begin
        sum_d   = acc_q;
        ret_d   = (acc_q == expected);
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mif.test_busy   = busy_q;
  assign mif.test_return = ret_q;
  assign mif.test_sum    = sum_q;
endmodule

// File: tb/tb_test_method_responder.sv
module tb_test_method_responder;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   nb;
  int   stray;

  test_method_if #(.WIDTH(32)) mif ();

  test_method_responder #(.WIDTH(32), .MAX_N(1000)) dut (
    .clk   (clk),
    .reset (reset),
    .mif   (mif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Raise req with idx, then count busy cycles sampled on negedges.
  // hold keeps req high; pulse_at (>0) injects a second req pulse with idx=3.
  task automatic call_and_wait(input logic [31:0] idx, input bit hold,
                               input int pulse_at, output int busy_cyc);
    mif.test_idx = idx;
    mif.test_req = 1'b1;
    busy_cyc = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (k == 0 && !hold) mif.test_req = 1'b0;
      if (pulse_at > 0 && k == pulse_at) begin
        mif.test_req = 1'b1;
        mif.test_idx = 32'd3;
      end
      if (pulse_at > 0 && k == pulse_at + 1) mif.test_req = 1'b0;
      if (mif.test_busy === 1'b1) busy_cyc++;
      else break;
    end
  endtask

  initial begin
    reset        = 1'b0;
    mif.test_req = 1'b0;
    mif.test_idx = '0;

    // Reset over cycles 3..8
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy",   mif.test_busy,   0);
    check("rst_return", mif.test_return, 0);
    check("rst_sum",    mif.test_sum,    0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (92) @(negedge clk);

    // 1: idx = 0
    call_and_wait(32'd0, 1'b0, 0, nb);
    check("t1_busy_len", nb, 2);
    check("t1_return", mif.test_return, 1);
    check("t1_sum",    mif.test_sum,    0);
    repeat (2) @(negedge clk);

    // 2: idx = 10
    call_and_wait(32'd10, 1'b0, 0, nb);
    check("t2_busy_len", nb, 12);
    check("t2_return", mif.test_return, 1);
    check("t2_sum",    mif.test_sum,    55);
    repeat (5) @(negedge clk);
    check("t2_hold_sum", mif.test_sum, 55);

    // 3: idx = MAX_N+1 rejected
    call_and_wait(32'd1001, 1'b0, 0, nb);
    check("t3_busy_len", nb, 1);
    check("t3_return", mif.test_return, 0);
    check("t3_sum",    mif.test_sum,    0);
    repeat (2) @(negedge clk);

    // 4: idx = MAX_N, req held high through completion and 50 more cycles
    call_and_wait(32'd1000, 1'b1, 0, nb);
    check("t4_busy_len", nb, 1002);
    check("t4_return", mif.test_return, 1);
    check("t4_sum",    mif.test_sum,    500500);
    stray = 0;
    repeat (50) begin
      @(negedge clk);
      if (mif.test_busy !== 1'b0) stray++;
    end
    check("t4_no_restart", stray, 0);
    mif.test_req = 1'b0;
    repeat (2) @(negedge clk);

    // 5: idx = 20 with an ignored mid-call pulse
    call_and_wait(32'd20, 1'b0, 5, nb);
    check("t5_busy_len", nb, 22);
    check("t5_return", mif.test_return, 1);
    check("t5_sum",    mif.test_sum,    210);
    repeat (3) @(negedge clk);
    check("t5_no_requeue", mif.test_busy, 0);

    // 6: idx = 100, async reset mid-ACC
    mif.test_idx = 32'd100;
    mif.test_req = 1'b1;
    @(negedge clk);
    mif.test_req = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_busy_mid", mif.test_busy, 1);
    check("t6_return_mid", mif.test_return, 0);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_busy",   mif.test_busy,   0);
    check("t6_rst_return", mif.test_return, 0);
    check("t6_rst_sum",    mif.test_sum,    0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    call_and_wait(32'd4, 1'b0, 0, nb);
    check("t6_busy_len", nb, 6);
    check("t6_return", mif.test_return, 1);
    check("t6_sum",    mif.test_sum,    10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
